// File: rtl/game_judge_pkg.sv
// Shared definitions for the game judge: FSM state encoding, default game
// constants and a small popcount helper for the enemy-hit vector.
package game_judge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY_C = 2'd1,
    PLAY_I = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_INIT_LIVES   = 3;
  localparam int DEF_MAX_LIVES    = 7;
  localparam int DEF_CLASSIC_TIME = 60;
  localparam int DEF_KILL_TARGET  = 20;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Seconds prescaler for the classic round timer.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   clear      : restart the count at 0 (round start)
//   run        : advance the count this cycle
//   tick       : one-cycle pulse on the cycle the count wraps CLK_HZ-1 -> 0
module game_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = run && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_judge.sv
// Game judge: tracks score, lives and classic round time, and decides when a
// classic or infinity round is over and whether it was won.
// Ports:
//   clk, rst_n                      : system clock, async active-low reset
//   enable_game_classic/_infinity   : mode-controller levels selecting a round
//   mytank_hit, enytank_hit[3:0]    : one-cycle destruction pulses
//   reward_life                     : one-cycle extra-life pulse
//   gameover_classic/_infinity, win : round result levels
//   score[15:0], lives[2:0], time_left[7:0] : round counters
//
// state  | meaning
// IDLE   | no round; waiting for an enable, pulses ignored
// PLAY_C | classic round: kills, lives and seconds countdown
// PLAY_I | infinity round: ends only when lives run out
// OVER   | round finished; results frozen until both enables drop
module game_judge
  import game_judge_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int INIT_LIVES   = DEF_INIT_LIVES,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int CLASSIC_TIME = DEF_CLASSIC_TIME,
  parameter int KILL_TARGET  = DEF_KILL_TARGET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_game_classic,
  input  logic        enable_game_infinity,
  input  logic        mytank_hit,
  input  logic [3:0]  enytank_hit,
  input  logic        reward_life,
  output logic        gameover_classic,
  output logic        gameover_infinity,
  output logic        win,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [7:0]  time_left
);

  localparam logic [2:0]  INIT_L = 3'(INIT_LIVES);
  localparam logic [2:0]  MAX_L  = 3'(MAX_LIVES);
  localparam logic [7:0]  TIME_C = 8'(CLASSIC_TIME);
  localparam logic [15:0] KILL_T = 16'(KILL_TARGET);

  state_t      state, state_n;
  logic [15:0] score_n, upd_score;
  logic [2:0]  lives_n, upd_lives;
  logic [7:0]  time_n, upd_time;
  logic        win_n, goc_n, goi_n;
  logic        clear, tick;
  logic [16:0] ssum;
  logic [3:0]  lsum;

  game_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .run   (state == PLAY_C),
    .tick  (tick)
  );

  // Candidate counter updates for a playing cycle; the FSM decides whether
  // they are committed.
  always_comb begin
    ssum      = {1'b0, score} + {14'b0, popcount4(enytank_hit)};
    upd_score = ssum[16] ? 16'hFFFF : ssum[15:0];

    // Reward is added before the hit is taken so hit+reward is neutral even
    // at the floor; a lone hit at 0 lives stays at 0.
    lsum = {1'b0, lives} + {3'b000, reward_life};
    if (mytank_hit && (lsum != 4'd0)) lsum = lsum - 4'd1;
    upd_lives = (lsum > {1'b0, MAX_L}) ? MAX_L : lsum[2:0];

    upd_time = (tick && (time_left != 8'd0)) ? time_left - 8'd1 : time_left;
  end

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    time_n  = time_left;
    win_n   = win;
    goc_n   = gameover_classic;
    goi_n   = gameover_infinity;
    clear   = 1'b0;

    case (state)
      IDLE: begin
        if (enable_game_classic || enable_game_infinity) begin
          state_n = enable_game_classic ? PLAY_C : PLAY_I;
          score_n = '0;
          lives_n = INIT_L;
          time_n  = enable_game_classic ? TIME_C : 8'd0;
          win_n   = 1'b0;
          clear   = 1'b1;
        end
      end
      PLAY_C: begin
        score_n = upd_score;
        lives_n = upd_lives;
        time_n  = upd_time;
        if ((upd_lives == 3'd0) || (upd_time == 8'd0) || (upd_score >= KILL_T)) begin
          state_n = OVER;
          goc_n   = 1'b1;
          win_n   = (upd_score >= KILL_T) && (upd_lives != 3'd0);
        end else if (!enable_game_classic) begin
          state_n = IDLE;
        end
      end
      PLAY_I: begin
        score_n = upd_score;
        lives_n = upd_lives;
        if (upd_lives == 3'd0) begin
          state_n = OVER;
          goi_n   = 1'b1;
        end else if (!enable_game_infinity) begin
          state_n = IDLE;
        end
      end
      OVER: begin
        if (!enable_game_classic && !enable_game_infinity) begin
          state_n = IDLE;
          goc_n   = 1'b0;
          goi_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      score             <= '0;
      lives             <= '0;
      time_left         <= '0;
      win               <= 1'b0;
      gameover_classic  <= 1'b0;
      gameover_infinity <= 1'b0;
    end else begin
      state             <= state_n;
      score             <= score_n;
      lives             <= lives_n;
      time_left         <= time_n;
      win               <= win_n;
      gameover_classic  <= goc_n;
      gameover_infinity <= goi_n;
    end
  end

endmodule

// File: tb/tb_game_judge.sv
// Randomized and directed bench for game_judge with a queue-based scoreboard.
module tb_game_judge;

  localparam int CLK_HZ = 10;
  localparam int INIT_L = 3;
  localparam int MAX_L  = 7;
  localparam int TIME_C = 60;
  localparam int KILL_T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ec = 1'b0, ei = 1'b0, mh = 1'b0, rw = 1'b0;
  logic [3:0]  eh = 4'b0;
  logic        goc, goi, win;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [7:0]  time_left;

  always #5 clk = ~clk;

  game_judge #(
    .CLK_HZ(CLK_HZ), .INIT_LIVES(INIT_L), .MAX_LIVES(MAX_L),
    .CLASSIC_TIME(TIME_C), .KILL_TARGET(KILL_T)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable_game_classic  (ec),
    .enable_game_infinity (ei),
    .mytank_hit           (mh),
    .enytank_hit          (eh),
    .reward_life          (rw),
    .gameover_classic     (goc),
    .gameover_infinity    (goi),
    .win                  (win),
    .score                (score),
    .lives                (lives),
    .time_left            (time_left)
  );

  typedef struct packed {
    logic [15:0] score;
    logic [2:0]  lives;
    logic [7:0]  tl;
    logic        win;
    logic        goc;
    logic        goi;
  } snap_t;

  snap_t exp_q[$];
  int total = 0, bad = 0, pushes = 0, pops = 0;

  // Reference model: game rules in plain integer arithmetic.
  localparam int PH_IDLE = 0, PH_CLASSIC = 1, PH_INF = 2, PH_DONE = 3;
  int m_phase = PH_IDLE;
  int m_score = 0, m_lives = 0, m_time = 0, m_cyc = 0;
  bit m_win = 0, m_goc = 0, m_goi = 0;

  function automatic snap_t model_snap();
    snap_t s;
    s.score = 16'(m_score);
    s.lives = 3'(m_lives);
    s.tl    = 8'(m_time);
    s.win   = m_win;
    s.goc   = m_goc;
    s.goi   = m_goi;
    return s;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_score = 0; m_lives = 0; m_time = 0; m_cyc = 0;
    m_win = 0; m_goc = 0; m_goi = 0;
  endtask

  task automatic model_step(input bit c, input bit i, input bit h,
                            input logic [3:0] e, input bit r);
    int ns, nl;
    case (m_phase)
      PH_IDLE: begin
        if (c || i) begin
          m_phase = c ? PH_CLASSIC : PH_INF;
          m_score = 0; m_lives = INIT_L; m_cyc = 0; m_win = 0;
          m_time  = c ? TIME_C : 0;
        end
      end
      PH_CLASSIC, PH_INF: begin
        ns = m_score + $countones(e);
        if (ns > 65535) ns = 65535;
        nl = m_lives - int'(h) + int'(r);
        if (nl > MAX_L) nl = MAX_L;
        if (nl < 0) nl = 0;
        m_score = ns;
        m_lives = nl;
        if (m_phase == PH_CLASSIC) begin
          m_cyc++;
          if (m_cyc == CLK_HZ) begin
            m_cyc = 0;
            if (m_time > 0) m_time--;
          end
          if (nl == 0 || m_time == 0 || ns >= KILL_T) begin
            m_phase = PH_DONE;
            m_goc   = 1;
            m_win   = (ns >= KILL_T) && (nl != 0);
          end else if (!c) m_phase = PH_IDLE;
        end else begin
          if (nl == 0) begin
            m_phase = PH_DONE;
            m_goi   = 1;
          end else if (!i) m_phase = PH_IDLE;
        end
      end
      default: begin
        if (!c && !i) begin
          m_phase = PH_IDLE;
          m_goc = 0; m_goi = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit c, input bit i, input bit h,
                      input logic [3:0] e, input bit r);
    @(negedge clk);
    rst_n = 1'b1;
    ec = c; ei = i; mh = h; eh = e; rw = r;
    model_step(c, i, h, e, r);
    exp_q.push_back(model_snap());
    pushes++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    ec = 0; ei = 0; mh = 0; eh = 4'b0; rw = 0;
    #1;
    total++;
    if (score != 16'd0 || lives != 3'd0 || time_left != 8'd0 ||
        win || goc || goi) begin
      bad++;
      $display("FAIL reset_async got score=%0d lives=%0d tl=%0d win=%0b goc=%0b goi=%0b want all 0",
               score, lives, time_left, win, goc, goi);
    end
    model_reset();
    exp_q.push_back(model_snap());
    pushes++;
    repeat (n) begin
      @(negedge clk);
      exp_q.push_back(model_snap());
      pushes++;
    end
  endtask

  // Monitor: one expected snapshot per clock after each issued stimulus.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        a = '{score: score, lives: lives, tl: time_left, win: win, goc: goc, goi: goi};
        total++;
        if (a != e) begin
          bad++;
          $display("FAIL snapshot t=%0t got score=%0d lives=%0d tl=%0d win=%0b goc=%0b goi=%0b want score=%0d lives=%0d tl=%0d win=%0b goc=%0b goi=%0b",
                   $time, a.score, a.lives, a.tl, a.win, a.goc, a.goi,
                   e.score, e.lives, e.tl, e.win, e.goc, e.goi);
        end
      end
    end
  end

  initial begin
    int guard;
    bit rc, ri;

    do_reset(3);

    // Classic timeout with no hits
    step(1, 0, 0, 4'b0, 0);
    repeat (TIME_C * CLK_HZ + 5) step(1, 0, 0, 4'b0, 0);
    repeat (3) step(0, 0, 0, 4'b0, 0);

    // Classic win: 16 single kills then a quad kill
    step(1, 0, 0, 4'b0, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 0, 4'b0001 << (k % 4), 0);
      step(1, 0, 0, 4'b0, 0);
    end
    step(1, 0, 0, 4'b1111, 0);
    repeat (4) step(1, 0, 1, 4'b1010, 1);
    repeat (3) step(0, 0, 0, 4'b0, 0);

    // Infinity: three deaths end the round, flag holds until enable drops
    step(0, 1, 0, 4'b0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 4'b0100, 0);
      step(0, 1, 0, 4'b0, 0);
      step(0, 1, 0, 4'b0, 0);
    end
    repeat (5) step(0, 1, 1, 4'b1111, 1);
    repeat (3) step(0, 0, 0, 4'b0, 0);

    // Simultaneous hit and reward at lives=1, then reward saturation
    step(0, 1, 0, 4'b0, 0);
    step(0, 1, 1, 4'b0, 0);
    step(0, 1, 1, 4'b0, 0);
    step(0, 1, 1, 4'b0, 1);
    repeat (3) step(0, 1, 0, 4'b0, 0);
    step(0, 0, 0, 4'b0, 0);
    step(0, 0, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    repeat (6) begin
      step(0, 1, 0, 4'b0, 1);
      step(0, 1, 0, 4'b0, 0);
    end
    step(0, 1, 0, 4'b0, 1);
    repeat (2) step(0, 0, 0, 4'b0, 0);

    // Reset mid classic round with score 5
    step(1, 0, 0, 4'b0, 0);
    repeat (5) step(1, 0, 0, 4'b0010, 0);
    do_reset(2);
    repeat (5) step(0, 0, 0, 4'b0, 0);
    step(1, 0, 0, 4'b0, 0);
    repeat (12) step(1, 0, 0, 4'b0, 0);
    repeat (2) step(0, 0, 0, 4'b0, 0);

    // Both enables: classic priority; hits in OVER ignored
    step(1, 1, 0, 4'b0, 0);
    repeat (3) step(1, 1, 0, 4'b0, 0);
    repeat (5) step(1, 1, 0, 4'b1111, 0);
    repeat (4) step(1, 1, 1, 4'b1111, 1);
    repeat (3) step(0, 0, 0, 4'b0, 0);

    // Random play
    rc = 0; ri = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 79) == 0) rc = ~rc;
      if ($urandom_range(0, 79) == 0) ri = ~ri;
      step(rc, ri,
           ($urandom_range(0, 15) == 0),
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
           ($urandom_range(0, 11) == 0));
      if (k == 1500) do_reset(1);
    end
    repeat (3) step(0, 0, 0, 4'b0, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    total++;
    if (exp_q.size() != 0 || pops != pushes) begin
      bad++;
      $display("FAIL drain got pops=%0d left=%0d want pops=%0d left=0",
               pops, exp_q.size(), pushes);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
